// File: rtl/lcd_nibble_writer_if.sv
// Request/LCD-pin bundle for lcd_nibble_writer: byte request handshake in, 4-bit LCD bus out.
interface lcd_nibble_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       in_rs;
    logic       in_nib_only;
    logic       rs;
    logic       en;
    logic [3:0] data;
    logic       busy;

    modport master (
        output in_valid, in_byte, in_rs, in_nib_only,
        input  in_ready, busy, rs, en, data
    );

    modport slave (
        input  in_valid, in_byte, in_rs, in_nib_only,
        output in_ready, busy, rs, en, data
    );
endinterface

// File: rtl/lcd_nibble_writer.sv
// HD44780-style 4-bit LCD writer: sends a byte as two timed EN-strobed nibbles, then waits.
// Optional macro LCD_LONG_CMD_WAIT_EN: clear/home commands (0x01/0x02, rs=0) use LONG_WAIT_CYC.
module lcd_nibble_writer #(
    parameter int SETUP_CYC     = 2,
    parameter int EN_HIGH_CYC   = 12,
    parameter int HOLD_CYC      = 2,
    parameter int NIB_GAP_CYC   = 50,
    parameter int WAIT_CYC      = 2000,
    parameter int LONG_WAIT_CYC = 80000
) (
    input  logic                 clk,
    input  logic                 reset,
    lcd_nibble_writer_if.slave   bus
);

    function automatic int eff(input int c);
        return (c < 1) ? 1 : c;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter is sized for the longest phase in every build so it never wraps.
    localparam int MAX_CYC = max2(max2(max2(eff(SETUP_CYC), eff(EN_HIGH_CYC)),
                                       max2(eff(HOLD_CYC), eff(NIB_GAP_CYC))),
                                  max2(eff(WAIT_CYC), eff(LONG_WAIT_CYC)));
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] L_SETUP = CW'(eff(SETUP_CYC) - 1);
    localparam logic [CW-1:0] L_EN    = CW'(eff(EN_HIGH_CYC) - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(eff(HOLD_CYC) - 1);
    localparam logic [CW-1:0] L_GAP   = CW'(eff(NIB_GAP_CYC) - 1);
    localparam logic [CW-1:0] L_WAIT  = CW'(eff(WAIT_CYC) - 1);
`ifdef LCD_LONG_CMD_WAIT_EN
    localparam logic [CW-1:0] L_LONG  = CW'(eff(LONG_WAIT_CYC) - 1);
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP_H, S_EN_H, S_HOLD_H, S_GAP,
        S_SETUP_L, S_EN_L, S_HOLD_L, S_WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          nib_only_q, nib_only_d;
    logic [3:0]    data_q, data_d;
    logic          en_q, en_d;
    logic          last;
    logic [CW-1:0] wait_load;

    always_comb begin
`ifdef LCD_LONG_CMD_WAIT_EN
        wait_load = (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ? L_LONG : L_WAIT;
`else
        wait_load = L_WAIT;
`endif
    end

    // cnt_q holds the remaining cycles of the current phase minus one.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        rs_d       = rs_q;
        nib_only_d = nib_only_q;
        data_d     = data_q;
        last       = (cnt_q == '0);
        cnt_d      = last ? cnt_q : cnt_q - CW'(1);
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    byte_d     = bus.in_byte;
                    rs_d       = bus.in_rs;
                    nib_only_d = bus.in_nib_only;
                    data_d     = bus.in_byte[7:4];
                    cnt_d      = L_SETUP;
                    state_d    = S_SETUP_H;
                end
            end
            S_SETUP_H: if (last) begin state_d = S_EN_H;   cnt_d = L_EN;   end
            S_EN_H:    if (last) begin state_d = S_HOLD_H; cnt_d = L_HOLD; end
            S_HOLD_H: begin
                if (last) begin
                    if (nib_only_q) begin
                        state_d = S_WAIT;
                        cnt_d   = wait_load;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = L_GAP;
                    end
                end
            end
            S_GAP: begin
                if (last) begin
                    state_d = S_SETUP_L;
                    cnt_d   = L_SETUP;
                    data_d  = byte_q[3:0];
                end
            end
            S_SETUP_L: if (last) begin state_d = S_EN_L;   cnt_d = L_EN;      end
            S_EN_L:    if (last) begin state_d = S_HOLD_L; cnt_d = L_HOLD;    end
            S_HOLD_L:  if (last) begin state_d = S_WAIT;   cnt_d = wait_load; end
            S_WAIT:    if (last) begin state_d = S_IDLE;   cnt_d = '0;        end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        en_d = (state_d == S_EN_H) || (state_d == S_EN_L);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            byte_q     <= '0;
            rs_q       <= 1'b0;
            nib_only_q <= 1'b0;
            data_q     <= '0;
            en_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            nib_only_q <= nib_only_d;
            data_q     <= data_d;
            en_q       <= en_d;
        end
    end

    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.rs       = rs_q;
    assign bus.en       = en_q;
    assign bus.data     = data_q;

endmodule
